regfile_writeback_ctrl: RTL and testbench
=========================================

// Module: regfile_writeback_ctrl
// PURPOSE
//  Write-side driver for the 32x64 RISC-V integer register file: merges ALU and load results
//  into one write port (RegWrite/RD/WriteData). Load results have priority, are aligned and
//  sign/zero-extended here, and are never stalled. ALU results that lose arbitration wait in a
//  DEPTH-entry FIFO with a valid/ready handshake. Sits between execute/memory stages and the register file.
// PARAMETERS
//  DEPTH   4   ALU pending-FIFO entries; power of 2, >=2
//  XLEN    64  datapath width; only 64 supported
// PORTS
//  clk          in   1     clock, rising edge
//  reset        in   1     synchronous, active-low reset
//  alu_valid    in   1     ALU result offered
//  alu_ready    out  1     ALU result accepted this cycle when alu_valid && alu_ready
//  alu_rd       in   5     ALU destination register
//  alu_data     in   64    ALU result
//  mem_valid    in   1     load result present; always accepted
//  mem_rd       in   5     load destination register
//  mem_funct3   in   3     000 lb,001 lh,010 lw,011 ld,100 lbu,101 lhu,110 lwu,111 illegal
//  mem_offset   in   3     byte address[2:0] of the load
//  mem_rdata    in   64    raw aligned doubleword from data memory
//  RegWrite     out  1     register-file write enable (registered)
//  RD           out  5     register-file write address (registered)
//  WriteData    out  64    register-file write data (registered)
//  pending_cnt  out  $clog2(DEPTH)+1  FIFO occupancy
//  load_err     out  1     one-cycle pulse: illegal funct3 or misaligned load
// BEHAVIOUR
//  - Reset (reset==0 at posedge): RegWrite=0, RD=0, WriteData=0, load_err=0, FIFO emptied,
//    pending_cnt=0; alu_ready=0 while reset is low. In-flight entries are discarded.
//  - alu_ready = !full (combinational from count); no push when full, even if popping that cycle.
//  - Per cycle, priority: (1) mem_valid -> write load result; (2) FIFO non-empty -> pop head,
//    write it; (3) FIFO empty && alu_valid -> write ALU result directly (no push); else RegWrite=0.
//  - An accepted ALU result not written this cycle is pushed; FIFO order is strict FIFO.
//  - Latency: load 1 cycle; ALU 1 cycle if not blocked, else 1 + queueing delay.
//  - Load extract: byte=rdata>>(8*offset); lb/lh/lw sign-extend 8/16/32 bits; lbu/lhu/lwu zero-extend; ld raw.
//  - Misaligned (lh/lhu offset[0]!=0; lw/lwu offset[1:0]!=0; ld offset!=0) or funct3==111:
//    no register write, load_err=1 for one cycle; the slot is not used, so the FIFO may pop.
//  - rd==0 (either source): consumed normally, slot used, RegWrite forced 0 (x0 stays zero).
//  - Simultaneous push and pop with count<DEPTH: count unchanged; pointers wrap modulo DEPTH.
// CONFIGURATION
//  - RF_BYPASS_EN defined: adds inputs RS1,RS2 (5) and outputs fwd1_hit,fwd2_hit (1),
//    fwd1_data,fwd2_data (64). Combinational lookup of the newest pending value for RSn in
//    priority: current registered write (RegWrite&&RD==RSn) > youngest FIFO entry matching RSn.
//    RSn==0 never hits.
//  - RF_BYPASS_EN undefined: ports absent, no comparators built.
// STRUCTURE
//  - Package regfile_wb_pkg: XLEN, funct3 load encodings (LB..LWU), typedef wb_entry_t {rd[4:0], data[63:0]}.
//  - Sub-module load_extend: combinational (funct3, offset, rdata) -> (data, misaligned/illegal).
//  - FIFO, arbitration, and output registers in this module.
// TESTING
//  - ALU only: alu rd=5, data=0x1234 each cycle, no loads -> RegWrite=1, RD=5 next cycle, pending_cnt=0.
//  - Load blocks ALU: mem_valid for 5 cycles + alu_valid for 5 cycles, DEPTH=4 -> loads written first,
//    4 ALU queued, alu_ready=0 on the 5th; drains in order after loads end.
//  - Extend: rdata=0x80FF_7F01_8000_00F0, lb offset 7 -> 0xFFFF_FFFF_FFFF_FF80; lhu offset 2 -> 0x0000_0000_0000_8000.
//  - Errors: lw offset=2 -> load_err pulse, RegWrite=0; funct3=111 -> same; alu rd=0 -> RegWrite=0.
//  - Reset mid-drain with 3 queued -> after reset: pending_cnt=0, RegWrite=0, no stale writes.
//  - RF_BYPASS_EN: queue rd=7 with data 1, then 2; RS1=7 -> fwd1_hit=1, fwd1_data=2; RS2=0 -> fwd2_hit=0.

Source files
------------

// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the register-file write-back controller.
package regfile_wb_pkg;

  localparam int unsigned XLEN = 64;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_funct3_e;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_ctrl_load_extend.sv
// Load result alignment and sign/zero extension; flags misaligned or illegal loads.
module load_extend
  import regfile_wb_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      offset_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o,
  output logic            err_o
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = rdata_i >> {offset_i, 3'b000};
    data_o  = '0;
    err_o   = 1'b0;
    case (funct3_i)
      LB:  data_o = {{56{shifted[7]}}, shifted[7:0]};
      LH: begin
        data_o = {{48{shifted[15]}}, shifted[15:0]};
        err_o  = offset_i[0];
      end
      LW: begin
        data_o = {{32{shifted[31]}}, shifted[31:0]};
        err_o  = |offset_i[1:0];
      end
      LD: begin
        data_o = shifted;
        err_o  = |offset_i;
      end
      LBU: data_o = {56'd0, shifted[7:0]};
      LHU: begin
        data_o = {48'd0, shifted[15:0]};
        err_o  = offset_i[0];
      end
      LWU: begin
        data_o = {32'd0, shifted[31:0]};
        err_o  = |offset_i[1:0];
      end
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// Merges load and ALU results into a single registered register-file write port.
// Optional forwarding lookup enabled with `define RF_BYPASS_EN.
module regfile_writeback_ctrl
  import regfile_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XW    = XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [4:0]               alu_rd,
  input  logic [XW-1:0]            alu_data,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [2:0]               mem_funct3,
  input  logic [2:0]               mem_offset,
  input  logic [XW-1:0]            mem_rdata,
`ifdef RF_BYPASS_EN
  input  logic [4:0]               RS1,
  input  logic [4:0]               RS2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [XW-1:0]            fwd1_data,
  output logic [XW-1:0]            fwd2_data,
`endif
  output logic                     RegWrite,
  output logic [4:0]               RD,
  output logic [XW-1:0]            WriteData,
  output logic [$clog2(DEPTH):0]   pending_cnt,
  output logic                     load_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  wb_entry_t        fifo_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             regwrite_q, regwrite_d;
  logic [4:0]       rd_q;
  logic [XW-1:0]    wdata_q;
  logic             load_err_q;

  logic [XW-1:0]    ld_data;
  logic             ld_err;
  logic             mem_slot, empty, full, accept, pop, direct, push, slot_used;
  wb_entry_t        wb_d;

  load_extend u_load_extend (
    .funct3_i (mem_funct3),
    .offset_i (mem_offset),
    .rdata_i  (mem_rdata),
    .data_o   (ld_data),
    .err_o    (ld_err)
  );

  // A faulting load gives up its slot, so the queue or a direct ALU write may use it.
  always_comb begin
    mem_slot  = mem_valid && !ld_err;
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    alu_ready = reset && !full;
    accept    = alu_valid && alu_ready;
    pop       = !mem_slot && !empty;
    direct    = !mem_slot && empty && accept;
    push      = accept && !direct;
    slot_used = mem_slot || pop || direct;
    count_d   = count_q + CW'(push) - CW'(pop);

    wb_d = '0;
    if (mem_slot) begin
      wb_d.rd   = mem_rd;
      wb_d.data = ld_data;
    end else if (pop) begin
      wb_d = fifo_q[rd_ptr_q];
    end else if (direct) begin
      wb_d.rd   = alu_rd;
      wb_d.data = alu_data;
    end
    regwrite_d = slot_used && (wb_d.rd != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      load_err_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      load_err_q <= mem_valid && ld_err;
      count_q    <= count_d;
      if (slot_used) begin
        rd_q    <= wb_d.rd;
        wdata_q <= wb_d.data;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= '{rd: alu_rd, data: alu_data};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign RegWrite    = regwrite_q;
  assign RD          = rd_q;
  assign WriteData   = wdata_q;
  assign pending_cnt = count_q;
  assign load_err    = load_err_q;

`ifdef RF_BYPASS_EN
  logic [4:0]    rs   [2];
  logic          hit  [2];
  logic [XW-1:0] fdat [2];
  logic [PW-1:0] idx;

  // Scan oldest to youngest so the youngest match wins; the registered write overrides.
  always_comb begin
    rs[0] = RS1;
    rs[1] = RS2;
    idx   = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      hit[p]  = 1'b0;
      fdat[p] = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = rd_ptr_q + PW'(i);
        if ((CW'(i) < count_q) && (fifo_q[idx].rd == rs[p])) begin
          hit[p]  = 1'b1;
          fdat[p] = fifo_q[idx].data;
        end
      end
      if (regwrite_q && (rd_q == rs[p])) begin
        hit[p]  = 1'b1;
        fdat[p] = wdata_q;
      end
      if (rs[p] == 5'd0) begin
        hit[p]  = 1'b0;
        fdat[p] = '0;
      end
    end
  end

  assign fwd1_hit  = hit[0];
  assign fwd2_hit  = hit[1];
  assign fwd1_data = fdat[0];
  assign fwd2_data = fdat[1];
`endif

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed self-checking bench for regfile_writeback_ctrl (DEPTH=4).
module tb_regfile_writeback_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3, mem_offset;
  logic [63:0] mem_rdata;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [63:0] WriteData;
  logic [2:0]  pending_cnt;
  logic        load_err;
`ifdef RF_BYPASS_EN
  logic [4:0]  RS1, RS2;
  logic        fwd1_hit, fwd2_hit;
  logic [63:0] fwd1_data, fwd2_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_writeback_ctrl #(.DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_rd      (mem_rd),
    .mem_funct3  (mem_funct3),
    .mem_offset  (mem_offset),
    .mem_rdata   (mem_rdata),
`ifdef RF_BYPASS_EN
    .RS1         (RS1),
    .RS2         (RS2),
    .fwd1_hit    (fwd1_hit),
    .fwd2_hit    (fwd2_hit),
    .fwd1_data   (fwd1_data),
    .fwd2_data   (fwd2_data),
`endif
    .RegWrite    (RegWrite),
    .RD          (RD),
    .WriteData   (WriteData),
    .pending_cnt (pending_cnt),
    .load_err    (load_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off,
                      input logic [63:0] data);
    mem_valid  = 1'b1;
    mem_rd     = rd;
    mem_funct3 = f3;
    mem_offset = off;
    mem_rdata  = data;
  endtask

  task automatic check_wb(input string tag, input logic we, input logic [4:0] rd,
                          input logic [63:0] data);
    check({tag, "_we"}, 64'(RegWrite), 64'(we));
    if (we) begin
      check({tag, "_rd"}, 64'(RD), 64'(rd));
      check({tag, "_data"}, WriteData, data);
    end
  endtask

  initial begin
    reset = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_funct3 = '0; mem_offset = '0; mem_rdata = '0;
`ifdef RF_BYPASS_EN
    RS1 = '0; RS2 = '0;
`endif

    // Reset state
    tick(); tick();
    check("rst_we", 64'(RegWrite), 64'd0);
    check("rst_rd", 64'(RD), 64'd0);
    check("rst_data", WriteData, 64'd0);
    check("rst_cnt", 64'(pending_cnt), 64'd0);
    check("rst_err", 64'(load_err), 64'd0);
    check("rst_ready", 64'(alu_ready), 64'd0);
    reset = 1'b1;
    #1 check("ready_after_rst", 64'(alu_ready), 64'd1);

    // ALU only: direct write, one-cycle latency, nothing queued
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_wb("alu_only", 1'b1, 5'd5, 64'h1234);
      check("alu_only_cnt", 64'(pending_cnt), 64'd0);
    end
    alu_valid = 1'b0;
    tick();
    check("idle_we", 64'(RegWrite), 64'd0);

    // Loads block ALU: 4 results queue, 5th sees alu_ready=0
    for (int k = 0; k < 5; k++) begin
      load(5'(10 + k), 3'b011, 3'd0, 64'(100 + k));
      alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = 64'(160 + k);
      #1 check("blk_ready", 64'(alu_ready), (k < 4) ? 64'd1 : 64'd0);
      tick();
      check_wb("blk_load", 1'b1, 5'(10 + k), 64'(100 + k));
      check("blk_cnt", 64'(pending_cnt), (k < 4) ? 64'(k + 1) : 64'd4);
    end
    // Drain: full pops without push, then push+pop keeps count, then empties in order
    mem_valid = 1'b0;
    #1 check("drain_ready_full", 64'(alu_ready), 64'd0);
    tick();
    check_wb("drain0", 1'b1, 5'd20, 64'd160);
    check("drain0_cnt", 64'(pending_cnt), 64'd3);
    check("drain_ready", 64'(alu_ready), 64'd1);
    tick();
    check_wb("drain1", 1'b1, 5'd21, 64'd161);
    check("drain1_cnt", 64'(pending_cnt), 64'd3);
    alu_valid = 1'b0;
    for (int j = 2; j < 5; j++) begin
      tick();
      check_wb("drain", 1'b1, 5'(20 + j), 64'(160 + j));
      check("drain_cnt", 64'(pending_cnt), 64'(4 - j));
    end
    tick();
    check("drained_we", 64'(RegWrite), 64'd0);

    // Load extraction
    load(5'd3, 3'b000, 3'd7, 64'h80FF_7F01_8000_00F0);
    tick(); check_wb("lb7", 1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FF80);
    load(5'd3, 3'b101, 3'd2, 64'h80FF_7F01_8000_00F0);
    tick(); check_wb("lhu2", 1'b1, 5'd3, 64'h0000_0000_0000_8000);
    load(5'd4, 3'b010, 3'd4, 64'h80FF_7F01_8000_00F0);
    tick(); check_wb("lw4", 1'b1, 5'd4, 64'hFFFF_FFFF_80FF_7F01);
    load(5'd4, 3'b110, 3'd4, 64'h80FF_7F01_8000_00F0);
    tick(); check_wb("lwu4", 1'b1, 5'd4, 64'h0000_0000_80FF_7F01);
    load(5'd6, 3'b100, 3'd0, 64'h80FF_7F01_8000_00F0);
    tick(); check_wb("lbu0", 1'b1, 5'd6, 64'h0000_0000_0000_00F0);
    load(5'd6, 3'b001, 3'd6, 64'h80FF_7F01_8000_00F0);
    tick(); check_wb("lh6", 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_80FF);

    // Errors: misaligned / illegal loads pulse load_err with no write
    load(5'd8, 3'b010, 3'd2, 64'h1);
    tick();
    check("lw_mis_err", 64'(load_err), 64'd1);
    check("lw_mis_we", 64'(RegWrite), 64'd0);
    mem_valid = 1'b0;
    tick();
    check("err_pulse_end", 64'(load_err), 64'd0);
    load(5'd8, 3'b111, 3'd0, 64'h1);
    tick();
    check("f3_ill_err", 64'(load_err), 64'd1);
    check("f3_ill_we", 64'(RegWrite), 64'd0);
    load(5'd8, 3'b011, 3'd4, 64'h1);
    tick();
    check("ld_mis_err", 64'(load_err), 64'd1);
    check("ld_mis_we", 64'(RegWrite), 64'd0);
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hDEAD;
    tick();
    check("x0_we", 64'(RegWrite), 64'd0);
    check("x0_err", 64'(load_err), 64'd0);
    check("x0_cnt", 64'(pending_cnt), 64'd0);
    alu_valid = 1'b0;

    // Queue three entries (rd 7, 7, 13) behind loads, then reset mid-drain
    for (int c = 0; c < 3; c++) begin
      load(5'd1, 3'b011, 3'd0, 64'd0);
      alu_valid = 1'b1;
      alu_rd    = (c < 2) ? 5'd7 : 5'd13;
      alu_data  = 64'(c + 1);
      tick();
    end
    alu_valid = 1'b0;
    check("q3_cnt", 64'(pending_cnt), 64'd3);
`ifdef RF_BYPASS_EN
    RS1 = 5'd7; RS2 = 5'd0;
    #1;
    check("fwd1_hit", 64'(fwd1_hit), 64'd1);
    check("fwd1_data", fwd1_data, 64'd2);
    check("fwd2_hit", 64'(fwd2_hit), 64'd0);
`endif
    mem_valid = 1'b0;
    tick();
    check_wb("pre_rst_pop", 1'b1, 5'd7, 64'd1);
    reset = 1'b0;
    tick();
    check("midrst_cnt", 64'(pending_cnt), 64'd0);
    check("midrst_we", 64'(RegWrite), 64'd0);
    check("midrst_ready", 64'(alu_ready), 64'd0);
    reset = 1'b1;
    tick();
    check("post_rst_we0", 64'(RegWrite), 64'd0);
    check("post_rst_cnt", 64'(pending_cnt), 64'd0);
    tick();
    check("post_rst_we1", 64'(RegWrite), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
